mul_div_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit. Sits directly downstream of the ALU function-code decoder and consumes the 6-bit SPECIAL funct codes that the decoder passes through for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Runs beside the single-cycle ALU. Owns the architectural HI/LO registers. Exposes busy/done so the pipeline stalls MFHI/MFLO and any new mul/div until the current operation completes.

---
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative HI/LO multiply/divide unit (shift-add / restoring)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int         CW       = $clog2(ITER);
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   count;
  logic [63:0]     prod;
  logic [31:0]     oper;
  logic            is_div;
  logic            neg_res;
  logic            neg_rem;
  logic            div_zero;

  logic            is_mul_op;
  logic            is_div_op;
  logic            signed_op;
  logic [31:0]     a_val;
  logic [31:0]     b_val;
  logic            last;
  logic [32:0]     mul_sum;
  logic [63:0]     mul_next;
  logic [32:0]     div_shift;
  logic            div_borrow;
  logic [31:0]     div_diff;
  logic [63:0]     div_next;
  logic [63:0]     prod_neg;
  logic [31:0]     quo_neg;
  logic [31:0]     rem_neg;
  logic [31:0]     fix_hi;
  logic [31:0]     fix_lo;

  assign is_mul_op = (funct == FN_MULT) || (funct == FN_MULTU);
  assign is_div_op = (funct == FN_DIV)  || (funct == FN_DIVU);
  // Signed variants have funct[0] clear; they latch magnitudes instead of raw values.
  assign signed_op = ~funct[0];
  assign a_val     = (signed_op && opA[31]) ? -opA : opA;
  assign b_val     = (signed_op && opB[31]) ? -opB : opB;
  assign last      = (count == CW'(ITER - 1));
  assign busy      = (state != IDLE);

  // Multiply: prod = {accumulator, multiplier}, shifted right once per step.
  assign mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, oper} : 33'd0);
  assign mul_next  = {mul_sum, prod[31:1]};

  // Divide: prod = {remainder, dividend/quotient}, shifted left once per step.
  assign div_shift  = {prod[63:32], prod[31]};
  assign div_borrow = (div_shift < {1'b0, oper});
  assign div_diff   = div_shift[31:0] - oper;
  assign div_next   = div_borrow ? {div_shift[31:0], prod[30:0], 1'b0}
                                 : {div_diff,         prod[30:0], 1'b1};

  assign prod_neg = -prod;
  assign quo_neg  = -prod[31:0];
  assign rem_neg  = -prod[63:32];

  always_comb begin
    fix_hi = neg_res ? prod_neg[63:32] : prod[63:32];
    fix_lo = neg_res ? prod_neg[31:0]  : prod[31:0];
    if (is_div) begin
      fix_hi = neg_rem ? rem_neg : prod[63:32];
      fix_lo = div_zero ? 32'hFFFF_FFFF : (neg_res ? quo_neg : prod[31:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && is_mul_op)      next_state = MUL;
        else if (start && is_div_op) next_state = DIV;
      end
      MUL:     if (last) next_state = FIX;
      DIV:     if (last) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      count    <= '0;
      prod     <= 64'd0;
      oper     <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (funct == FN_MTHI) hi <= opA;
            if (funct == FN_MTLO) lo <= opA;
            if (is_mul_op) begin
              oper     <= a_val;
              prod     <= {32'd0, b_val};
              neg_res  <= signed_op && (opA[31] ^ opB[31]);
              neg_rem  <= 1'b0;
              div_zero <= 1'b0;
              is_div   <= 1'b0;
              count    <= '0;
            end
            if (is_div_op) begin
              oper     <= b_val;
              prod     <= {32'd0, a_val};
              neg_res  <= signed_op && (opA[31] ^ opB[31]);
              neg_rem  <= signed_op && opA[31];
              div_zero <= (opB == 32'd0);
              is_div   <= 1'b1;
              count    <= '0;
            end
          end
        end
        MUL: begin
          prod  <= mul_next;
          count <= count + 1'b1;
        end
        DIV: begin
          prod  <= div_next;
          count <= count + 1'b1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : scoreboard bench for mul_div_unit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mul_div_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .opA(opA), .opB(opB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} built from native SV arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int     ia, ib, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      FN_MULT:  begin p = sa * sb; return p; end
      FN_MULTU: return {32'd0, a} * {32'd0, b};
      FN_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      FN_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called at a negedge; holds start for one cycle and returns at the next negedge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    start = 1'b1;
    funct = f;
    opA   = a;
    opB   = b;
    if (push) exp_q.push_back(model(f, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int already);
    int          n;
    logic [63:0] e;
    n = already;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check({tag, "_done"}, 64'(done), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    end else begin
      check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b, 1'b1);
    wait_done(tag, 0);
    @(negedge clk);
    check({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int          done_seen;
    logic [5:0]  fsel [4];
    fsel[0] = FN_MULT; fsel[1] = FN_MULTU; fsel[2] = FN_DIV; fsel[3] = FN_DIVU;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    issue(FN_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    exp_hi = 32'h1234_5678;
    check("mthi_hi",   64'(hi),   64'(exp_hi));
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(FN_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
    exp_lo = 32'h9ABC_DEF0;
    check("mtlo_lo",   64'(lo),   64'(exp_lo));
    check("mtlo_hi",   64'(hi),   64'(exp_hi));
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    issue(6'b100000, 32'hDEAD_BEEF, 32'h1, 1'b0);
    check("bad_funct_busy", 64'(busy), 64'd0);
    check("bad_funct_hi",   64'(hi),   64'(exp_hi));
    check("bad_funct_lo",   64'(lo),   64'(exp_lo));

    run_op("mult_m3x5",    FN_MULT,  32'hFFFF_FFFD, 32'd5);
    run_op("multu_ffxff",  FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_ffxff",   FN_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_minneg",  FN_MULT,  32'h8000_0000, 32'h8000_0000);
    run_op("div_m7d2",     FN_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op("divu_100d7",   FN_DIVU,  32'd100,       32'd7);
    run_op("divu_100d0",   FN_DIVU,  32'd100,       32'd0);
    run_op("div_m7d0",     FN_DIV,   32'hFFFF_FFF9, 32'd0);
    run_op("div_overflow", FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_7dm2",     FN_DIV,   32'd7,         32'hFFFF_FFFE);

    // Start in the done cycle must be accepted.
    issue(FN_MULT, 32'd7, 32'hFFFF_FFF7, 1'b1);
    wait_done("b2b_first", 0);
    issue(FN_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b1);
    wait_done("b2b_second", 0);
    @(negedge clk);

    // A MULT arriving mid-DIV is ignored.
    issue(FN_DIV, 32'hFFFF_FF00, 32'd9, 1'b1);
    repeat (4) @(negedge clk);
    issue(FN_MULT, 32'd3, 32'd3, 1'b0);
    wait_done("div_intruded", 5);
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("intrude_extra_done", 64'(done_seen), 64'd0);
    check("intrude_idle", 64'(busy), 64'd0);

    // Reset in the middle of a multiply discards it.
    issue(FN_MULT, 32'h1234_5678, 32'h0000_0100, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi",   64'(hi),   64'(exp_hi));
    check("midreset_lo",   64'(lo),   64'(exp_lo));
    check("midreset_done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'd0);
    run_op("post_reset_divu", FN_DIVU, 32'd1000, 32'd33);

    for (int i = 0; i < 10; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = fsel[$urandom_range(0, 3)];
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), f, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
